// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I control path: datapath widths, major
// opcode values, execution-unit indices and the sequencer state encoding.
// No ports; imported by the sequencer and the opcode decoder.
package cpu_pkg;

   localparam int XLEN           = 32;
   localparam int REG_SELECT_LEN = 5;

   // RV32I major opcodes (instruction[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Execution-unit indices into unit_enable_n
   localparam int UNIT_LUI    = 0;
   localparam int UNIT_AUIPC  = 1;
   localparam int UNIT_JAL    = 2;
   localparam int UNIT_JALR   = 3;
   localparam int UNIT_BRANCH = 4;
   localparam int UNIT_LOAD   = 5;
   localparam int UNIT_STORE  = 6;
   localparam int UNIT_OP_IMM = 7;
   localparam int UNIT_OP     = 8;
   localparam int UNIT_COUNT  = 9;

   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXECUTE = 3'd2,
      COMMIT  = 3'd3,
      TRAP    = 3'd4
   } seq_state_t;

   // A PC target is usable only when it is word aligned.
   function automatic logic pc_aligned(input logic [1:0] pc_low);
      return (pc_low == 2'b00);
   endfunction

endpackage

// File: rtl/exec_sequencer_opcode_decoder.sv
// opcode_decoder: purely combinational map from the major opcode to the
// one-hot execution-unit select.
//   opcode      in  7          instruction[6:0]
//   unit_onehot out UNIT_COUNT one bit per execution unit, all zero if unknown
//   valid       out 1          opcode is a supported RV32I major opcode
module opcode_decoder
   import cpu_pkg::*;
(
   input  logic [6:0]            opcode,
   output logic [UNIT_COUNT-1:0] unit_onehot,
   output logic                  valid
);

   // Unit lookup; anything without the 32-bit encoding marker (2'b11) is rejected.
   always_comb begin
      unit_onehot = {UNIT_COUNT{1'b0}};
      if (opcode[1:0] == 2'b11) begin
         case (opcode)
            OPC_LUI:    unit_onehot[UNIT_LUI]    = 1'b1;
            OPC_AUIPC:  unit_onehot[UNIT_AUIPC]  = 1'b1;
            OPC_JAL:    unit_onehot[UNIT_JAL]    = 1'b1;
            OPC_JALR:   unit_onehot[UNIT_JALR]   = 1'b1;
            OPC_BRANCH: unit_onehot[UNIT_BRANCH] = 1'b1;
            OPC_LOAD:   unit_onehot[UNIT_LOAD]   = 1'b1;
            OPC_STORE:  unit_onehot[UNIT_STORE]  = 1'b1;
            OPC_OP_IMM: unit_onehot[UNIT_OP_IMM] = 1'b1;
            OPC_OP:     unit_onehot[UNIT_OP]     = 1'b1;
            default:    unit_onehot = {UNIT_COUNT{1'b0}};
         endcase
      end else begin
         unit_onehot = {UNIT_COUNT{1'b0}};
      end
      valid = |unit_onehot;
   end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle FETCH/DECODE/EXECUTE/COMMIT control FSM for
// the RV32I core. Owns the architectural PC and the retired-instruction count.
//   clk, reset                  clock, asynchronous active-high reset
//   imem_req/addr/ready/rdata   instruction fetch handshake
//   instruction, program_counter broadcast to all execution units
//   unit_enable_n               one-hot-low unit enable
//   unit_busy                   active unit extends EXECUTE
//   load_new_program_counter,
//   new_program_counter         PC redirect bus from the units
//   output_register             writeback select from the units
//   rf_write_en                 register-file write strobe (COMMIT only)
//   illegal_instr, halted       sticky trap indication
//   instret                     retired-instruction counter
module exec_sequencer #(
   parameter int               XLEN        = 32,
   parameter logic [XLEN-1:0]  RESET_PC    = {XLEN{1'b0}},
   parameter int               EXEC_CYCLES = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   output logic                               imem_req,
   output logic [XLEN-1:0]                    imem_addr,
   input  logic                               imem_ready,
   input  logic [XLEN-1:0]                    imem_rdata,
   output logic [XLEN-1:0]                    instruction,
   output logic [XLEN-1:0]                    program_counter,
   output logic [cpu_pkg::UNIT_COUNT-1:0]     unit_enable_n,
   input  logic                               unit_busy,
   input  logic                               load_new_program_counter,
   input  logic [XLEN-1:0]                    new_program_counter,
   input  logic [cpu_pkg::REG_SELECT_LEN-1:0] output_register,
   output logic                               rf_write_en,
   output logic                               illegal_instr,
   output logic                               halted,
   output logic [63:0]                        instret
);
   import cpu_pkg::*;

   localparam logic [3:0] EXEC_LIMIT = 4'(EXEC_CYCLES);

   seq_state_t            state;
   logic [3:0]            exec_count;
   logic [UNIT_COUNT-1:0] dec_onehot;
   logic                  dec_valid;
   logic                  taken;
   logic [XLEN-1:0]       next_pc;
   logic                  next_pc_ok;

   opcode_decoder u_decoder (
      .opcode      (instruction[6:0]),
      .unit_onehot (dec_onehot),
      .valid       (dec_valid)
   );

   assign imem_addr = program_counter;

   // Commit target: an undriven (Z/X) redirect line counts as not taken.
   always_comb begin
      taken = (load_new_program_counter === 1'b1);
      if (taken) begin
         next_pc = new_program_counter;
      end else begin
         next_pc = program_counter + XLEN'(3'd4);
      end
      next_pc_ok = pc_aligned(next_pc[1:0]);
   end

   // Write strobe is qualified by the alignment check so a trapping commit never writes.
   assign rf_write_en = (state == COMMIT) && next_pc_ok &&
                        (output_register != {REG_SELECT_LEN{1'b0}});

   // Sequencer FSM with registered handshake, enable and status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= FETCH;
         program_counter <= RESET_PC;
         instruction     <= {XLEN{1'b0}};
         unit_enable_n   <= {UNIT_COUNT{1'b1}};
         imem_req        <= 1'b0;
         illegal_instr   <= 1'b0;
         halted          <= 1'b0;
         instret         <= 64'd0;
         exec_count      <= 4'd0;
      end else begin
         case (state)
            FETCH: begin
               // Accept only while the request is visible to memory.
               if (imem_req && imem_ready) begin
                  instruction <= imem_rdata;
                  imem_req    <= 1'b0;
                  state       <= DECODE;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            DECODE: begin
               if (dec_valid) begin
                  unit_enable_n <= ~dec_onehot;
                  exec_count    <= 4'd1;
                  state         <= EXECUTE;
               end else begin
                  illegal_instr <= 1'b1;
                  halted        <= 1'b1;
                  state         <= TRAP;
               end
            end
            EXECUTE: begin
               if ((exec_count >= EXEC_LIMIT) && !unit_busy) begin
                  state <= COMMIT;
               end else if (exec_count != 4'hF) begin
                  exec_count <= exec_count + 4'd1;
               end else begin
                  // Saturate while a slow unit keeps the window open.
                  exec_count <= exec_count;
               end
            end
            COMMIT: begin
               unit_enable_n <= {UNIT_COUNT{1'b1}};
               exec_count    <= 4'd0;
               if (next_pc_ok) begin
                  program_counter <= next_pc;
                  instret         <= instret + 64'd1;
                  imem_req        <= 1'b1;
                  state           <= FETCH;
               end else begin
                  illegal_instr <= 1'b1;
                  halted        <= 1'b1;
                  state         <= TRAP;
               end
            end
            TRAP: begin
               unit_enable_n <= {UNIT_COUNT{1'b1}};
               imem_req      <= 1'b0;
               illegal_instr <= 1'b1;
               halted        <= 1'b1;
               state         <= TRAP;
            end
            default: begin
               // Corrupted state encoding: park safely.
               unit_enable_n <= {UNIT_COUNT{1'b1}};
               imem_req      <= 1'b0;
               illegal_instr <= 1'b1;
               halted        <= 1'b1;
               state         <= TRAP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: the driver plays instruction memory
// and the active execution unit, predicts each instruction's outcome with a
// behavioural model and queues it; a negedge monitor measures each
// instruction as observed on the pins and compares against the queue.
module tb_exec_sequencer;

   localparam int          XLEN        = 32;
   localparam int          EXEC_CYCLES = 2;
   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam logic [6:0]  OPC_TBL [9] = '{7'b0110111, 7'b0010111, 7'b1101111,
                                           7'b1100111, 7'b1100011, 7'b0000011,
                                           7'b0100011, 7'b0010011, 7'b0110011};

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic [31:0] program_counter;
   logic [8:0]  unit_enable_n;
   logic        unit_busy;
   logic        load_new_program_counter;
   logic [31:0] new_program_counter;
   logic [4:0]  output_register;
   logic        rf_write_en;
   logic        illegal_instr;
   logic        halted;
   logic [63:0] instret;

   exec_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC), .EXEC_CYCLES(EXEC_CYCLES)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .imem_req                 (imem_req),
      .imem_addr                (imem_addr),
      .imem_ready               (imem_ready),
      .imem_rdata               (imem_rdata),
      .instruction              (instruction),
      .program_counter          (program_counter),
      .unit_enable_n            (unit_enable_n),
      .unit_busy                (unit_busy),
      .load_new_program_counter (load_new_program_counter),
      .new_program_counter      (new_program_counter),
      .output_register          (output_register),
      .rf_write_en              (rf_write_en),
      .illegal_instr            (illegal_instr),
      .halted                   (halted),
      .instret                  (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] fetch_addr;
      logic [31:0] instr;
      int          unit;
      int          req_cycles;
      int          latency;
      int          low_cycles;
      int          we_cnt;
      logic [31:0] pc_after;
      logic [63:0] instret_after;
      logic        trap;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          passed = 0;
   logic [31:0] m_pc;
   logic [63:0] m_instret;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   function automatic int model_unit(input logic [31:0] ins);
      for (int i = 0; i < 9; i++) if (ins[6:0] == OPC_TBL[i]) return i;
      return -1;
   endfunction

   // ---------------- monitor ----------------
   logic        mon_fetch;
   logic [31:0] mon_addr;
   int          mon_req, mon_lat, mon_low, mon_we;
   logic [8:0]  mon_en;
   logic        mon_en_ok;
   logic        mon_stop;
   exp_t        mon_e;
   logic [8:0]  mon_exp_en;

   always @(negedge clk) begin
      if (reset) begin
         mon_fetch = 1'b0; mon_req = 0; mon_lat = 0; mon_low = 0; mon_we = 0;
         mon_en_ok = 1'b1; mon_stop = 1'b0; mon_en = 9'h1FF;
      end else if (!mon_stop) begin
         if (mon_fetch) mon_lat++;
         if (unit_enable_n != 9'h1FF) begin
            mon_low++;
            if (mon_low == 1) mon_en = unit_enable_n;
            else if (unit_enable_n != mon_en) mon_en_ok = 1'b0;
         end
         if (rf_write_en) mon_we++;
         if (mon_fetch && ((mon_low > 0 && unit_enable_n == 9'h1FF) || halted)) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_retire: got retire at pc %0h expected none", program_counter);
            end else begin
               mon_e = exp_q.pop_front();
               check("fetch_addr", mon_addr, mon_e.fetch_addr);
               check("req_cycles", mon_req, mon_e.req_cycles);
               check("latency", mon_lat, mon_e.latency);
               check("enable_cycles", mon_low, mon_e.low_cycles);
               if (mon_e.low_cycles > 0) begin
                  mon_exp_en = 9'h1FF;
                  mon_exp_en[mon_e.unit] = 1'b0;
                  check("enable_pattern", mon_en, mon_exp_en);
                  check("enable_stable", mon_en_ok, 1'b1);
               end
               check("instruction", instruction, mon_e.instr);
               check("we_pulses", mon_we, mon_e.we_cnt);
               check("pc_after", program_counter, mon_e.pc_after);
               check("instret_after", instret, mon_e.instret_after);
               check("halted", halted, mon_e.trap);
               check("illegal_instr", illegal_instr, mon_e.trap);
            end
            mon_fetch = 1'b0; mon_req = 0; mon_lat = 0; mon_low = 0; mon_we = 0;
            mon_en_ok = 1'b1;
            if (halted) mon_stop = 1'b1;
         end
         if (!halted) begin
            if (imem_req) mon_req++;
            if (imem_req && imem_ready) begin
               mon_fetch = 1'b1;
               mon_addr  = imem_addr;
               mon_lat   = 0;
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic apply_reset();
      reset = 1'b1; imem_ready = 1'b0; unit_busy = 1'b0;
      load_new_program_counter = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      m_pc = RESET_PC; m_instret = 64'd0;
      check("rst_imem_req", imem_req, 1'b0);
      check("rst_pc", program_counter, RESET_PC);
      check("rst_instret", instret, 64'd0);
      check("rst_enable", unit_enable_n, 9'h1FF);
      check("rst_halted", halted, 1'b0);
      check("rst_illegal", illegal_instr, 1'b0);
      check("rst_we", rf_write_en, 1'b0);
      check("rst_instruction", instruction, 32'd0);
      @(posedge clk);
      #1;
      check("req_first_edge", imem_req, 1'b1);
      check("req_addr", imem_addr, RESET_PC);
   endtask

   task automatic issue(input logic [31:0] ins, input int waits, input int nbusy,
                        input logic [4:0] rd, input logic ld, input logic [31:0] tgt,
                        input bit abort, output bit trapped);
      exp_t        e;
      int          u, ecyc, n;
      logic [31:0] nxt;
      u    = model_unit(ins);
      ecyc = (nbusy + 1 > EXEC_CYCLES) ? nbusy + 1 : EXEC_CYCLES;
      e.fetch_addr = m_pc; e.instr = ins; e.unit = u; e.req_cycles = waits + 1;
      e.trap = 1'b0; e.we_cnt = 0;
      if (u < 0) begin
         e.low_cycles = 0; e.latency = 2; e.trap = 1'b1;
      end else begin
         e.low_cycles = ecyc + 1; e.latency = ecyc + 3;
         nxt = ld ? tgt : m_pc + 32'd4;
         if (nxt[1:0] != 2'b00) e.trap = 1'b1;
         else begin
            e.we_cnt = (rd != 5'd0) ? 1 : 0;
            if (!abort) begin m_pc = nxt; m_instret = m_instret + 64'd1; end
         end
      end
      e.pc_after = m_pc; e.instret_after = m_instret;
      trapped = e.trap && !abort;
      if (!abort) exp_q.push_back(e);

      imem_ready = 1'b0;
      n = 0;
      while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
      if (!imem_req) check("req_timeout", imem_req, 1'b1);
      repeat (waits) begin @(posedge clk); #1; end
      imem_rdata = ins; imem_ready = 1'b1;
      load_new_program_counter = ld; new_program_counter = tgt;
      output_register = rd; unit_busy = 1'b0;
      @(posedge clk);
      #1;
      imem_ready = 1'b0; imem_rdata = $urandom;
      if (u < 0) return;
      unit_busy = (nbusy > 0);
      @(posedge clk);
      #1;
      if (abort) begin
         @(posedge clk);
         #2;
         reset = 1'b1;
         #1;
         check("abort_enable", unit_enable_n, 9'h1FF);
         check("abort_req", imem_req, 1'b0);
         check("abort_we", rf_write_en, 1'b0);
         check("abort_pc", program_counter, RESET_PC);
         check("abort_instret", instret, 64'd0);
         check("abort_instruction", instruction, 32'd0);
         check("abort_halted", halted, 1'b0);
         return;
      end
      for (int i = 0; i < nbusy; i++) begin @(posedge clk); #1; end
      unit_busy = 1'b0;
      n = 0;
      while (unit_enable_n != 9'h1FF && n < 60) begin @(posedge clk); #1; n++; end
      if (unit_enable_n != 9'h1FF) check("commit_timeout", unit_enable_n, 9'h1FF);
      load_new_program_counter = 1'b0;
      new_program_counter = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
      check("queue_drain", exp_q.size(), 0);
   endtask

   task automatic trap_check();
      int n = 0;
      int req_hi = 0;
      int we_hi = 0;
      while (!halted && n < 20) begin @(posedge clk); #1; n++; end
      check("trap_halted", halted, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (imem_req) req_hi++;
         if (rf_write_en) we_hi++;
      end
      check("trap_req_quiet", req_hi, 0);
      check("trap_we_quiet", we_hi, 0);
      check("trap_pc_hold", program_counter, m_pc);
      check("trap_illegal", illegal_instr, 1'b1);
      drain();
      apply_reset();
   endtask

   initial begin
      bit          tr;
      logic [31:0] ins, tgt;
      logic [4:0]  rd;
      logic        ld;
      int          u;
      reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0; unit_busy = 1'b0;
      load_new_program_counter = 1'b0; new_program_counter = 32'd0; output_register = 5'd0;
      m_pc = RESET_PC; m_instret = 64'd0;
      apply_reset();

      // Directed: ADDI, JALR with wait states, busy LOAD, x0 writeback, PC wrap.
      issue(32'h00500093, 0, 0, 5'd1, 1'b0, 32'd0, 1'b0, tr);
      issue(32'h000080E7, 3, 0, 5'd1, 1'b1, 32'h0000_0100, 1'b0, tr);
      issue(32'h0000_2083, 0, 5, 5'd1, 1'b0, 32'd0, 1'b0, tr);
      issue(32'h00000013, 1, 0, 5'd0, 1'b0, 32'd0, 1'b0, tr);
      issue(32'h0000006F, 0, 0, 5'd1, 1'b1, 32'hFFFF_FFFC, 1'b0, tr);
      issue(32'h00000013, 0, 0, 5'd0, 1'b0, 32'd0, 1'b0, tr);
      issue(32'h00500093, 0, 1, 5'd3, 1'b0, 32'd0, 1'b0, tr);
      drain();

      // Reset while a unit is enabled.
      issue(32'h00500093, 0, 3, 5'd1, 1'b0, 32'd0, 1'b1, tr);
      apply_reset();
      issue(32'h00500093, 2, 0, 5'd2, 1'b0, 32'd0, 1'b0, tr);

      // Illegal opcode trap.
      issue(32'h00000000, 0, 0, 5'd1, 1'b0, 32'd0, 1'b0, tr);
      trap_check();

      // Misaligned redirect trap.
      issue(32'h00500093, 0, 0, 5'd1, 1'b0, 32'd0, 1'b0, tr);
      issue(32'h000080E7, 0, 0, 5'd1, 1'b1, 32'h0000_0102, 1'b0, tr);
      if (tr) trap_check();

      // Randomized stream.
      for (int k = 0; k < 70; k++) begin
         u   = $urandom_range(0, 8);
         ins = $urandom;
         if ($urandom_range(0, 29) == 0) ins[6:0] = 7'($urandom_range(0, 127));
         else ins[6:0] = OPC_TBL[u];
         tgt = $urandom;
         tgt[1:0] = 2'b00;
         ld = 1'b0;
         if ((u == 2 || u == 3 || u == 4) && $urandom_range(0, 1) == 1) ld = 1'b1;
         if (ld && $urandom_range(0, 19) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         issue(ins, $urandom_range(0, 4), $urandom_range(0, 6), rd, ld, tgt, 1'b0, tr);
         if (tr) trap_check();
      end
      drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core.
- Fetches an instruction over a simple ready handshake, decodes the major opcode and asserts exactly one execution unit's active-low enable (jalr, jal, branch, op-imm, ...).
- Holds that enable for a fixed window, with a stall input for slow units, then commits the PC update and register writeback.
- Owns the architectural program counter and the retired-instruction counter.

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXEC_CYCLES, 2, minimum cycles in EXECUTE before COMMIT: 1 for the unit's registered register_src select, 1 for ALU settle; legal range 1..15

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request, held until imem_ready
imem_addr  out  XLEN  fetch address (= program_counter)
imem_ready  in  1  fetch data valid this cycle
imem_rdata  in  XLEN  fetched instruction word
instruction  out  XLEN  latched instruction, broadcast to all units
program_counter  out  XLEN  architectural PC, broadcast to all units
unit_enable_n  out  UNIT_COUNT  one-hot-low enable, one bit per execution unit
unit_busy  in  1  active unit requests more EXECUTE cycles
load_new_program_counter  in  1  shared bus from units, tri-stated when idle
new_program_counter  in  XLEN  shared bus from units
output_register  in  5  shared writeback select from units
rf_write_en  out  1  register-file write strobe, COMMIT only
illegal_instr  out  1  sticky flag: unknown opcode or misaligned target
halted  out  1  sequencer stopped in TRAP
instret  out  64  retired-instruction count

Behaviour:
- Reset (async, applied immediately): state=FETCH, program_counter=RESET_PC, instruction=0, unit_enable_n all ones, imem_req=0, rf_write_en=0, illegal_instr=0, halted=0, instret=0, exec counter=0.
- imem_req goes high on the first rising edge after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr=program_counter.
  - On a clk edge with imem_ready=1: latch imem_rdata into instruction, go to DECODE.
  - Any number of wait states is allowed.
  - imem_req drops the cycle after the accept.
- DECODE (1 cycle):
  - Map instruction[6:0] to a unit index: LUI 0, AUIPC 1, JAL 2, JALR 3, BRANCH 4, LOAD 5, STORE 6, OP_IMM 7, OP 8.
  - Also require instruction[1:0]==2'b11.
  - Unknown opcode: go to TRAP.
  - Otherwise go to EXECUTE and drive the selected unit_enable_n bit low from the next cycle.
- EXECUTE:
  - Exactly one enable is low.
  - The counter counts from 1.
  - Go to COMMIT when counter>=EXEC_CYCLES and unit_busy=0; unit_busy=1 holds EXECUTE indefinitely.
  - PC and instruction are stable for the whole window.
- COMMIT (1 cycle; enable stays low):
  - rf_write_en=1 iff output_register!=0; LOAD/STORE/BRANCH units drive x0 or rd as appropriate.
  - Next PC = new_program_counter if load_new_program_counter===1'b1, else program_counter+4. A Z or X value counts as not-taken.
  - If next PC[1:0]!=0: go to TRAP, PC unchanged, rf_write_en forced 0.
  - Otherwise: update PC, instret+=1, go to FETCH; the enable returns high in the FETCH cycle.
- TRAP: all enables high, imem_req=0, illegal_instr=1, halted=1; the only exit is reset.
- PC arithmetic wraps modulo 2^XLEN: 32'hFFFF_FFFC+4 gives 0, no trap.
- instret wraps at 2^64.
- Reset mid-EXECUTE or mid-FETCH: abandon immediately, no commit, no write strobe.
- Minimum latency per instruction with a zero-wait fetch: 1 (FETCH) + 1 (DECODE) + EXEC_CYCLES + 1 (COMMIT) = 5 cycles at default.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN, REG_SELECT_LEN
  - opcode localparams OPC_LUI..OPC_OP
  - unit index constants UNIT_LUI..UNIT_OP and UNIT_COUNT=9
  - typedef enum seq_state_t {FETCH, DECODE, EXECUTE, COMMIT, TRAP}
- One sub-module, opcode_decoder: combinational instruction to {unit one-hot, valid}. This lets the unit table be tested on its own.

Test Plan:
- Reset release, imem_ready=1 always, ADDI (32'h00500093) at PC 0: imem_req high cycle 1; unit_enable_n[7] low for cycles 3-5; rf_write_en pulse with output_register=1; PC=4 and instret=1 after cycle 5.
- JALR (32'h000080E7) with the unit driving load_new_program_counter=1 and new_program_counter=32'h0000_0100: PC=32'h100 after COMMIT, enable[3] only low bit; fetch with 3 wait states adds exactly 3 cycles.
- unit_busy held high 4 extra cycles on LOAD: EXECUTE lasts 6 cycles, a single rf_write_en pulse, instret +1.
- Opcode 7'b0000000 or new_program_counter=32'h0000_0102: illegal_instr=1 and halted=1; PC stays at the faulting address; no rf_write_en; imem_req stays 0 for 20 cycles.
- Reset asserted mid-EXECUTE: all outputs take reset values in the same cycle, before the next clk edge. After release, fetch restarts at RESET_PC and instret=0.
- output_register=0 in COMMIT: rf_write_en stays 0, PC still advances by 4; PC 32'hFFFF_FFFC wraps to 0.
